// File: rtl/ysyx_22041461_fetch_queue.sv
// ---------------------------------------------------------------------------
// ysyx_22041461_fetch_queue
//
// Instruction fetch stage. It generates sequential fetch PCs and issues them
// on a valid/ready request channel. In-order responses are collected into a
// DEPTH-entry {pc, inst} queue, and decode drains that queue through a
// valid/ready handshake.
//
// A redirect reloads the fetch PC and flushes the queue. Responses to requests
// that are still outstanding at the redirect are counted in 'drop' and are
// discarded silently when they arrive.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   redirect_valid  redirect fetch this cycle (highest priority)
//   redirect_pc     new fetch PC
//   mem_req_valid   fetch request valid (combinational)
//   mem_req_ready   memory accepts the request
//   mem_req_addr    fetch address (the current fetch PC)
//   mem_resp_valid  response beat, in order, never back-pressured
//   mem_resp_inst   fetched instruction
//   out_valid       queue head valid to decode
//   out_ready       decode accepts the head
//   out_pc          PC of the head instruction (0 when the queue is empty)
//   out_inst        head instruction (0 when the queue is empty)
// ---------------------------------------------------------------------------
module ysyx_22041461_fetch_queue #(
  parameter int unsigned     PC_W     = 64,
  parameter int unsigned     INST_W   = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [PC_W-1:0]   mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [INST_W-1:0] mem_resp_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 2;

  logic [PC_W-1:0]   fetch_pc;

  // Instruction queue and the tag FIFO that remembers the address of every
  // live in-flight request. Both FIFOs share the same DEPTH.
  logic [PC_W-1:0]   q_pc    [DEPTH];
  logic [INST_W-1:0] q_inst  [DEPTH];
  logic [PC_W-1:0]   tag_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CNT_W-1:0]  count, inflight, drop;

  logic [SUM_W-1:0]  occupancy;
  logic              credit;
  logic              req_fire;
  logic              resp_drop;
  logic              resp_live;
  logic              resp_used;
  logic              out_fire;

  // Every queue slot is reserved by a request at issue time. A slot is also
  // held by a response that is going to be dropped. This guarantees that an
  // unthrottled response never finds the queue full.
  assign occupancy = SUM_W'(count) + SUM_W'(inflight) + SUM_W'(drop);
  assign credit    = occupancy < SUM_W'(DEPTH);

  assign mem_req_valid = rst && credit && !redirect_valid;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // While drop is non-zero, every response belongs to a request issued
  // before the last redirect.
  assign resp_drop = mem_resp_valid && (drop != '0);
  assign resp_live = mem_resp_valid && (drop == '0) && (inflight != '0);
  assign resp_used = resp_drop || resp_live;

  assign out_valid = (count != '0) && !redirect_valid;
  assign out_fire  = out_valid && out_ready;
  assign out_pc    = (count != '0) ? q_pc[rd_ptr]   : '0;
  assign out_inst  = (count != '0) ? q_inst[rd_ptr] : '0;

  // NOTE: non-blocking assignments, so every register in this block samples
  // the values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // Every outstanding request becomes a drop. A response arriving in
      // this cycle retires one of them immediately.
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= drop + inflight - CNT_W'(resp_used);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PC_W'(PC_STEP);
        tag_wr   <= tag_wr + 1'b1;
      end
      if (resp_live) begin
        tag_rd <= tag_rd + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (out_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (resp_drop) begin
        drop <= drop - 1'b1;
      end
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(resp_live);
      count    <= count + CNT_W'(resp_live) - CNT_W'(out_fire);
    end
  end

  // NOTE: payload storage has no reset. The pointers and counters above
  // decide which entries are valid, and the outputs are gated by count.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr] <= fetch_pc;
    end
    if (resp_live && !redirect_valid) begin
      q_pc[wr_ptr]   <= tag_mem[tag_rd];
      q_inst[wr_ptr] <= mem_resp_inst;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is a memory-side protocol error.
  // The logic above ignores it, and this assertion flags it.
  resp_without_request : assert property (
    @(posedge clk) disable iff (!rst)
      mem_resp_valid |-> ((inflight != '0) || (drop != '0))
  );
`endif

endmodule

// File: doc/ysyx_22041461_fetch_queue.md
Name: ysyx_22041461_fetch_queue

Overview:
Parametrised next-generation instruction fetch stage. Generates sequential PCs, issues fetch requests to the instruction memory/ICACHE over a valid/ready request channel, and collects in-order responses into a DEPTH-entry {pc, inst} queue drained by decode through a valid/ready handshake. Supports redirect, which flushes the queue, reloads the PC and silently discards responses still in flight. It sits between the PC/branch logic and ID, replacing the single-beat valid-in/valid-out IF wrapper.

Parameters:
PC_W, 64, PC/address width
INST_W, 32, instruction width
DEPTH, 4, queue entries and maximum in-flight requests; power of 2, >=2
RESET_PC, 64'h8000_0000, fetch PC after reset
PC_STEP, 4, increment per sequential fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
redirect_valid  in  1  redirect fetch this cycle
redirect_pc  in  PC_W  new fetch PC
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  PC_W  fetch address
mem_resp_valid  in  1  response beat, in order, never back-pressured
mem_resp_inst  in  INST_W  fetched instruction
out_valid  out  1  queue head valid to decode
out_ready  in  1  decode accepts head
out_pc  out  PC_W  PC of head instruction
out_inst  out  INST_W  head instruction

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; queue empty (rd/wr ptr=0, count=0); inflight=0; drop=0. Outputs during/after reset: mem_req_valid=0 while rst=0, then as defined below; out_valid=0; out_pc/out_inst=0.
- State: fetch_pc; queue of DEPTH {pc,inst}; pc-tag FIFO of DEPTH holding addresses of live in-flight requests; counters inflight, drop, count, each clog2(DEPTH)+1 bits.
- Credit: issue allowed iff count+inflight+drop < DEPTH. Guarantees that no response overflows the queue.
- mem_req_valid = rst && credit && !redirect_valid (combinational); mem_req_addr=fetch_pc.
- Request handshake (valid&&ready): push fetch_pc to tag FIFO, inflight+1, fetch_pc += PC_STEP (wraps modulo 2^PC_W).
- Response with drop>0: drop-1, data discarded, queue untouched. Response with drop=0: pop tag FIFO, write {tag,inst} at wr ptr, count+1, inflight-1. The entry is visible on out_* the next cycle (1-cycle response-to-out latency, no bypass).
- out_valid = (count!=0) && !redirect_valid; out_pc/out_inst = head entry (registered storage, stable while out_valid && !out_ready). Handshake pops the head; rd ptr wraps at DEPTH.
- Same-cycle push and pop: count unchanged; a pop on a full queue plus a push is legal.
- Redirect (highest priority): next fetch_pc=redirect_pc; queue cleared (count=0, ptrs=0); tag FIFO cleared; drop <= drop + inflight + (response this cycle ? -1 : 0), i.e. every outstanding request, including those accepted in earlier cycles, is discarded. No request is issued in the redirect cycle. A response arriving in the redirect cycle is discarded. Back-to-back redirects: the last one wins; the drop count accumulates correctly.
- mem_resp_valid with inflight=0 and drop=0 is a protocol error: ignore it and flag a simulation assertion.
- mem_req_addr is held stable while mem_req_valid && !mem_req_ready unless a redirect occurs, which may change it (the request is withdrawn).

Test Plan:
- Reset then mem_req_ready=1, 1-cycle-delay memory returning inst=addr[31:0] -> out stream pc 0x80000000,0x80000004,0x80000008... with matching inst, and out_valid continuous from the 3rd cycle.
- out_ready=0 held, DEPTH=4 -> exactly 4 requests issued, mem_req_valid drops, count=4; raise out_ready -> one new request issued per pop.
- Memory with latency 3 and 3 requests in flight, redirect_pc=0x80001000 -> the 3 old responses are discarded (drop 3->0), and the first out_pc is 0x80001000.
- Redirect in the same cycle as a response and out_ready=1 -> no out handshake, that response is dropped, and no request is issued that cycle.
- fetch_pc=2^PC_W-4 via redirect -> the next request address is 0 (wrap).
- rst asserted mid-stream with 2 queued and 2 in flight -> outputs immediately 0, counters 0, and the first request after release is at RESET_PC.
